btn_cond: RTL and testbench

BTN_COND -- requirements
Module: btn_cond

---
 rtl/btn_cond.sv | 114 +++++++++++
 tb/tb_btn_cond.sv | 122 ++++++++++++
 2 files changed

// File: rtl/btn_cond.sv
// Pushbutton conditioner: sync, debounce and single-shot/auto-repeat pulse generation for up/down buttons.
// Latency: raw edge to level is DB_CYCLES+1 cycles, level to first pulse is 1 cycle; no backpressure, pulses are fire-and-forget.
module btn_cond #(
  parameter int DB_CYCLES  = 50000,
  parameter int RPT_DELAY  = 25000000,
  parameter int RPT_PERIOD = 5000000,
  parameter int CNTW       = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  output logic up,
  output logic down,
  output logic up_level,
  output logic down_level
);

  localparam logic [CNTW-1:0] DB_LAST   = CNTW'((DB_CYCLES > 0) ? DB_CYCLES - 1 : 0);
  localparam logic [CNTW-1:0] DELAY_LD  = CNTW'(RPT_DELAY);
  localparam logic [CNTW-1:0] PERIOD_LD = CNTW'(RPT_PERIOD);
  localparam logic [CNTW-1:0] ONE       = CNTW'(1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT, LOCK} state_t;
  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  // Channel index 0 is up, 1 is down.
  logic [1:0]           sync1, sync2, lvl;
  logic [1:0][CNTW-1:0] db_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1  <= '0;
      sync2  <= '0;
      lvl    <= '0;
      db_cnt <= '0;
    end else begin
      sync1 <= {btn_down, btn_up};
      sync2 <= sync1;
      for (int c = 0; c < 2; c++) begin
        if (sync2[c] == lvl[c]) begin
          db_cnt[c] <= '0;
        end else if (db_cnt[c] >= DB_LAST) begin
          lvl[c]    <= ~lvl[c];
          db_cnt[c] <= '0;
        end else begin
          db_cnt[c] <= db_cnt[c] + ONE;
        end
      end
    end
  end

  assign up_level   = lvl[0];
  assign down_level = lvl[1];

  state_t          state;
  dir_t            dir;
  logic [CNTW-1:0] timer;
  logic            dir_lvl, opp_lvl, timer_exp;

  assign dir_lvl   = (dir == DIR_UP) ? lvl[0] : lvl[1];
  assign opp_lvl   = (dir == DIR_UP) ? lvl[1] : lvl[0];
  // Expiry on 1 so the reload lands on the same edge as the pulse.
  assign timer_exp = (timer <= ONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      dir   <= DIR_UP;
      timer <= '0;
      up    <= 1'b0;
      down  <= 1'b0;
    end else begin
      up   <= 1'b0;
      down <= 1'b0;
      case (state)
        IDLE: begin
          if (lvl == 2'b11) begin
            state <= LOCK;
          end else if (lvl[0]) begin
            up    <= 1'b1;
            dir   <= DIR_UP;
            timer <= DELAY_LD;
            state <= DELAY;
          end else if (lvl[1]) begin
            down  <= 1'b1;
            dir   <= DIR_DOWN;
            timer <= DELAY_LD;
            state <= DELAY;
          end
        end
        DELAY, REPEAT: begin
          if (opp_lvl) begin
            state <= LOCK;
          end else if (!dir_lvl) begin
            state <= IDLE;
          end else if (timer_exp) begin
            up    <= (dir == DIR_UP);
            down  <= (dir == DIR_DOWN);
            timer <= PERIOD_LD;
            state <= REPEAT;
          end else begin
            timer <= timer - ONE;
          end
        end
        LOCK: begin
          if (lvl == 2'b00) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_btn_cond.sv
// Directed bench for btn_cond with short debounce/repeat timings.
// Outputs are compared #1 after each rising edge as {up, down, up_level, down_level}.
module tb_btn_cond;

  logic clk = 1'b0;
  logic reset, btn_up, btn_down;
  logic up, down, up_level, down_level;
  logic [3:0] obs;

  int n_vec = 0;
  int n_bad = 0;

  btn_cond #(.DB_CYCLES(4), .RPT_DELAY(20), .RPT_PERIOD(8), .CNTW(8)) dut (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
    .up(up), .down(down), .up_level(up_level), .down_level(down_level)
  );

  always #5 clk = ~clk;
  assign obs = {up, down, up_level, down_level};

  typedef struct {
    logic       bu;
    logic       bd;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs [1:80];

  task automatic cyc(input logic u, input logic d);
    btn_up   = u;
    btn_down = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got {up,down,up_lvl,dn_lvl}=%b want %b", name, idx, got, exp);
    end
  endtask

  task automatic settle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0);
  endtask

  initial begin
    logic eu, ed;
    // Edges counted from reset release: clean up press at 10..19, then a 2-cycle down bounce at 41..70.
    for (int i = 1; i <= 80; i++) begin
      vecs[i].bu  = (i >= 10 && i <= 19);
      vecs[i].bd  = (i >= 41 && i <= 70) && (((i - 41) / 2) % 2 == 0);
      vecs[i].exp = {(i == 16), 1'b0, (i >= 15 && i <= 24), 1'b0};
    end

    reset = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    #2 reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_state", 0, obs, 4'b0000);
    reset = 1'b0;

    for (int i = 1; i <= 80; i++) begin
      cyc(vecs[i].bu, vecs[i].bd);
      check("table", i, obs, vecs[i].exp);
    end
    settle(10);

    // Long hold: pulses at T=6, T+20, then every 8 until level falls.
    for (int r = 0; r <= 130; r++) begin
      cyc(r <= 106, 1'b0);
      eu = (r == 6) || (r >= 26 && r <= 106 && (r - 26) % 8 == 0);
      check("hold_repeat", r, obs, {eu, 1'b0, (r >= 5 && r <= 111), 1'b0});
    end
    settle(10);

    // Down pressed during up REPEAT locks out both; later lone down gives one pulse.
    for (int r = 0; r <= 100; r++) begin
      cyc(r <= 60, (r >= 30 && r <= 60) || (r >= 80 && r <= 89));
      eu = (r == 6) || (r == 26) || (r == 34);
      ed = (r == 86);
      check("lock_in_repeat", r, obs,
            {eu, ed, (r >= 5 && r <= 65), (r >= 35 && r <= 65) || (r >= 85 && r <= 94)});
    end
    settle(10);

    // Simultaneous press locks with no pulse; a later lone up press behaves normally.
    for (int r = 0; r <= 45; r++) begin
      cyc((r <= 10) || (r >= 20 && r <= 29), r <= 10);
      check("both_pressed", r, obs,
            {(r == 26), 1'b0, (r >= 5 && r <= 15) || (r >= 25 && r <= 34), (r >= 5 && r <= 15)});
    end
    settle(10);

    // Reset mid-REPEAT with button still held.
    for (int r = 0; r <= 37; r++) begin
      cyc(1'b1, 1'b0);
      eu = (r == 6) || (r == 26) || (r == 34);
      check("pre_reset_hold", r, obs, {eu, 1'b0, (r >= 5), 1'b0});
    end
    reset = 1'b1;
    #1;
    check("reset_async", 37, obs, 4'b0000);
    for (int r = 38; r <= 40; r++) begin
      cyc(1'b1, 1'b0);
      check("in_reset", r, obs, 4'b0000);
    end
    reset = 1'b0;
    for (int r = 41; r <= 80; r++) begin
      cyc(1'b1, 1'b0);
      eu = (r == 47) || (r == 67) || (r == 75);
      check("post_reset_hold", r, obs, {eu, 1'b0, (r >= 46), 1'b0});
    end
    settle(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
